alu_resp_checker: RTL and testbench
===================================

# alu_resp_checker

Synthesizable response checker: the receiving end of the ALU stimulus interface used by the individual-unit benches. Accepts operand/opcode stimulus as it is driven into a unit under test, computes the expected result, queues it, and compares it against the unit's result when that result returns some cycles later. Keeps pass/fail counts and sticky error flags, so directed benches and on-board tests need no hand-checked waveforms.

## Interface
- WIDTH, 32, operand/result width
- DEPTH, 4, expected-result queue entries (power of 2, ≥2)
- CNT_W, 16, pass/fail counter width
- clock  in  1  system clock, rising edge
- clear  in  1  reset: synchronous, active-high
- stim_valid  in  1  stimulus present
- stim_ready  out  1  queue can accept (= not full)
- stim_op  in  3  000 AND, 001 OR, 010 NOT a, 011 NEG a, 100 ADD, 101 SUB, 11x reserved
- stim_a, stim_b  in  WIDTH  operands (Ra, Rb)
- res_valid  in  1  result from unit under test present
- res_z  in  WIDTH  result (Rz)
- pass_count, fail_count  out  CNT_W  compare outcomes
- busy  out  1  queue non-empty
- underflow_err  out  1  sticky: result arrived with queue empty
- illegal_op_err  out  1  sticky: reserved opcode accepted
- first_exp, first_got  out  WIDTH  expected/received of first mismatch
- first_idx  out  CNT_W  compare index (pass+fail before it) of first mismatch

## Operation
- Accept: stim_valid && stim_ready at a rising edge. Legal op: expected value computed combinationally, pushed at that edge. Reserved op: nothing pushed, illegal_op_err set.
- Expected: AND a&b; OR a|b; NOT ~a; NEG (~a)+1; ADD a+b; SUB a+(~b)+1; all modulo 2^WIDTH, carry discarded, b ignored for NOT/NEG.
- Compare: res_valid at a rising edge pops queue head; equal → pass_count+1, else fail_count+1. Results match stimulus strictly in order.
- First mismatch: on first failure since clear, capture head into first_exp, res_z into first_got, pass_count+fail_count (pre-increment) into first_idx; held until clear.
- Counters saturate at all-ones; no wrap.
- Queue: circular buffer, log2(DEPTH)-bit read/write pointers wrap; occupancy counter 0..DEPTH. stim_ready = (count != DEPTH); busy = (count != 0).
- Full: stim_ready low; stim_valid ignored, no error. Simultaneous push and pop while full is impossible (ready low); while non-empty and non-full both occur, count unchanged.
- Empty: res_valid sets underflow_err, no pop, no counter change — even if a push occurs the same edge (result must follow its stimulus by ≥1 cycle).
- No FSM beyond queue occupancy; states EMPTY/PARTIAL/FULL implied by count.

## Timing
- Reset (clear high at an edge): pointers, count, counters, all sticky flags, first_* to 0; stim_ready=1, busy=0 next cycle. Clear mid-operation discards queued expectations; a result arriving the cycle after clear flags underflow.
- clear dominates stim_valid/res_valid on the same edge.
- Minimum stimulus→result latency 1 cycle; maximum limited only by DEPTH outstanding entries.
- All outputs registered except stim_ready and busy (decoded from registered count); no combinational path from inputs to outputs.
- Throughput: one accept and one compare per cycle.

## Configuration
- ALU_CHECK_CAPTURE_EN defined: first_exp, first_got, first_idx and their capture logic present as above.
- Undefined: capture registers removed, those outputs tied to 0; counts and flags unchanged.

## Structure
- Shared package: opcode constants (OP_AND … OP_SUB), WIDTH/CNT_W defaults, expected-value function.
- One sub-module: alu_exp_fifo (parameterized WIDTH×DEPTH circular queue with push/pop/count/full/empty); checker top holds expected-value logic, counters, flags.

## Test plan
- OR FFFFFFFF|00000000, result FFFFFFFF after 2 cycles → pass_count=1, fail_count=0, busy back to 0.
- OR 88888888|00000001, result 88888889; then same stimulus with result 88888888 → pass=1, fail=1, first_exp=88888889, first_got=88888888, first_idx=1.
- Push 4 stimuli (ADD 1+1, SUB 0−1, NEG 1, NOT 0) with no results → stim_ready=0, 5th ignored; results 2, FFFFFFFF, FFFFFFFF, FFFFFFFF → pass=4.
- res_valid with empty queue → underflow_err=1, counters unchanged; op 110 accepted → illegal_op_err=1, busy stays 0.
- 3 stimuli queued, clear pulsed 1 cycle → all outputs 0, stim_ready=1; subsequent result → underflow_err=1.
- Force fail_count to all-ones via 2^CNT_W mismatches (CNT_W=4 override) → saturates at F.

Source files
------------

// File: rtl/alu_resp_checker_pkg.sv
// Shared opcode constants, size defaults and the expected-value function
// used by the ALU response checker.
package alu_resp_checker_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int DEPTH_DEF = 4;
  localparam int CNT_W_DEF = 16;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b010;
  localparam logic [2:0] OP_NEG = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;

  function automatic logic op_legal(logic [2:0] op);
    return op[2:1] != 2'b11;
  endfunction

  // Computed at 64 bits; callers keep the low WIDTH bits, which is exact
  // modulo 2^WIDTH for every op.
  function automatic logic [63:0] alu_exp(logic [2:0] op, logic [63:0] a, logic [63:0] b);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_NOT:  return ~a;
      OP_NEG:  return ~a + 64'd1;
      OP_ADD:  return a + b;
      OP_SUB:  return a + ~b + 64'd1;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/alu_exp_fifo.sv
// Circular queue of expected results: wrapping read/write pointers plus an
// occupancy count 0..DEPTH. Caller never pushes when full or pops when empty.
module alu_exp_fifo
  import alu_resp_checker_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PW-1:0]               wr_ptr, rd_ptr;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/alu_resp_checker.sv
// ALU response checker: queues expected results of accepted stimulus and
// scores returning results in order. ALU_CHECK_CAPTURE_EN keeps first-mismatch capture.
module alu_resp_checker
  import alu_resp_checker_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             stim_valid,
  output logic             stim_ready,
  input  logic [2:0]       stim_op,
  input  logic [WIDTH-1:0] stim_a,
  input  logic [WIDTH-1:0] stim_b,
  input  logic             res_valid,
  input  logic [WIDTH-1:0] res_z,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic             busy,
  output logic             underflow_err,
  output logic             illegal_op_err,
  output logic [WIDTH-1:0] first_exp,
  output logic [WIDTH-1:0] first_got,
  output logic [CNT_W-1:0] first_idx
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [63:0]      exp_full;
  logic [WIDTH-1:0] exp_val, q_head;
  logic [CW-1:0]    q_count;
  logic             q_full, q_empty, accept, push, pop, hit, unused_hi;

  assign exp_full  = alu_exp(stim_op, 64'(stim_a), 64'(stim_b));
  assign exp_val   = exp_full[WIDTH-1:0];
  assign unused_hi = ^exp_full;

  assign stim_ready = ~q_full;
  assign busy       = (q_count != '0);
  assign accept     = stim_valid & ~q_full;
  assign push       = accept & op_legal(stim_op);
  assign pop        = res_valid & ~q_empty;
  assign hit        = (res_z == q_head);

  alu_exp_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .din   (exp_val),
    .dout  (q_head),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  always_ff @(posedge clock) begin
    if (clear) begin
      pass_count     <= '0;
      fail_count     <= '0;
      underflow_err  <= 1'b0;
      illegal_op_err <= 1'b0;
    end else begin
      // A result needs a stimulus accepted on an earlier edge, so an
      // empty queue is an underflow even if a push lands this edge.
      if (res_valid & q_empty)                underflow_err  <= 1'b1;
      if (accept & ~op_legal(stim_op))        illegal_op_err <= 1'b1;
      if (pop & hit & (pass_count != '1))     pass_count <= pass_count + CNT_W'(1);
      if (pop & ~hit & (fail_count != '1))    fail_count <= fail_count + CNT_W'(1);
    end
  end

`ifdef ALU_CHECK_CAPTURE_EN
  // fail_count never returns to zero (saturating), so zero means no failure yet.
  always_ff @(posedge clock) begin
    if (clear) begin
      first_exp <= '0;
      first_got <= '0;
      first_idx <= '0;
    end else if (pop & ~hit & (fail_count == '0)) begin
      first_exp <= q_head;
      first_got <= res_z;
      first_idx <= pass_count + fail_count;
    end
  end
`else
  assign first_exp = '0;
  assign first_got = '0;
  assign first_idx = '0;
`endif

endmodule

// File: tb/tb_alu_resp_checker.sv
// Randomized and directed bench for alu_resp_checker against a queue-based
// reference model; a second instance with 4-bit counters covers saturation.
module tb_alu_resp_checker;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
`ifdef ALU_CHECK_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        stim_valid = 1'b0, res_valid = 1'b0;
  logic [2:0]  stim_op = 3'b000;
  logic [31:0] stim_a = '0, stim_b = '0, res_z = '0;

  logic        stim_ready, busy, underflow_err, illegal_op_err;
  logic [15:0] pass_count, fail_count, first_idx;
  logic [31:0] first_exp, first_got;

  logic        s_ready, s_busy, s_under, s_ill;
  logic [3:0]  s_pass, s_fail, s_idx;
  logic [31:0] s_fexp, s_fgot;

  always #5 clock = ~clock;

  alu_resp_checker #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(16)) dut (
    .clock(clock), .clear(clear), .stim_valid(stim_valid), .stim_ready(stim_ready),
    .stim_op(stim_op), .stim_a(stim_a), .stim_b(stim_b), .res_valid(res_valid), .res_z(res_z),
    .pass_count(pass_count), .fail_count(fail_count), .busy(busy),
    .underflow_err(underflow_err), .illegal_op_err(illegal_op_err),
    .first_exp(first_exp), .first_got(first_got), .first_idx(first_idx));

  alu_resp_checker #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(4)) dut_s (
    .clock(clock), .clear(clear), .stim_valid(stim_valid), .stim_ready(s_ready),
    .stim_op(stim_op), .stim_a(stim_a), .stim_b(stim_b), .res_valid(res_valid), .res_z(res_z),
    .pass_count(s_pass), .fail_count(s_fail), .busy(s_busy),
    .underflow_err(s_under), .illegal_op_err(s_ill),
    .first_exp(s_fexp), .first_got(s_fgot), .first_idx(s_idx));

  int n_chk = 0, n_pass = 0;

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mq[$];
  int          mp, mf, m_fp;
  bit          m_under, m_ill, chk_en = 1'b0;
  logic [31:0] m_fe, m_fg;

  function automatic logic [31:0] ref_exp(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return ~a;
      3'd3: return -a;
      3'd4: return a + b;
      default: return a - b;
    endcase
  endfunction

  function automatic int sat(int v, int w);
    int mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  always @(posedge clock) begin
    int n0;
    logic [31:0] e;
    if (clear) begin
      mq.delete(); mp = 0; mf = 0; m_fp = 0;
      m_under = 0; m_ill = 0; m_fe = 0; m_fg = 0; chk_en = 1;
    end else begin
      n0 = mq.size();
      if (res_valid) begin
        if (n0 == 0) m_under = 1;
        else begin
          e = mq.pop_front();
          if (e == res_z) mp++;
          else begin
            if (mf == 0) begin m_fe = e; m_fg = res_z; m_fp = mp; end
            mf++;
          end
        end
      end
      if (stim_valid && n0 < DEPTH) begin
        if (stim_op[2:1] == 2'b11) m_ill = 1;
        else mq.push_back(ref_exp(stim_op, stim_a, stim_b));
      end
    end
  end

  // Per-cycle comparison, 2 time units after the edge.
  initial begin
    forever begin
      @(posedge clock); #2;
      if (chk_en) begin
        check("ready",     stim_ready, mq.size() != DEPTH);
        check("busy",      busy, mq.size() != 0);
        check("pass",      pass_count, sat(mp, 16));
        check("fail",      fail_count, sat(mf, 16));
        check("underflow", underflow_err, m_under);
        check("illegal",   illegal_op_err, m_ill);
        check("first_exp", first_exp, CAP ? m_fe : 32'h0);
        check("first_got", first_got, CAP ? m_fg : 32'h0);
        check("first_idx", first_idx, CAP ? sat(m_fp, 16) : 0);
        check("s_ready",   s_ready, mq.size() != DEPTH);
        check("s_busy",    s_busy, mq.size() != 0);
        check("s_pass",    s_pass, sat(mp, 4));
        check("s_fail",    s_fail, sat(mf, 4));
        check("s_under",   s_under, m_under);
        check("s_ill",     s_ill, m_ill);
        check("s_fexp",    s_fexp, CAP ? m_fe : 32'h0);
        check("s_fgot",    s_fgot, CAP ? m_fg : 32'h0);
        check("s_idx",     s_idx, CAP ? sat(m_fp, 4) : 0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(bit sv, logic [2:0] op, logic [31:0] a, logic [31:0] b, bit rv, logic [31:0] z);
    @(negedge clock);
    clear = 1'b0; stim_valid = sv; stim_op = op; stim_a = a; stim_b = b;
    res_valid = rv; res_z = z;
  endtask

  task automatic idle();
    cyc(0, 3'd0, 0, 0, 0, 0);
  endtask

  task automatic clr();
    @(negedge clock);
    clear = 1'b1; stim_valid = 1'b0; res_valid = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 3))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    repeat (2) @(negedge clock);

    // OR all-ones, result two cycles later
    cyc(1, 3'b001, 32'hFFFF_FFFF, 32'h0, 0, 0);
    idle();
    cyc(0, 3'd0, 0, 0, 1, 32'hFFFF_FFFF);
    idle();
    check("t1_pass", pass_count, 1);
    check("t1_fail", fail_count, 0);
    check("t1_busy", busy, 0);

    // pass then mismatch, first-mismatch capture
    clr();
    cyc(1, 3'b001, 32'h8888_8888, 32'h1, 0, 0);
    cyc(1, 3'b001, 32'h8888_8888, 32'h1, 1, 32'h8888_8889);
    cyc(0, 3'd0, 0, 0, 1, 32'h8888_8888);
    idle();
    check("t2_pass", pass_count, 1);
    check("t2_fail", fail_count, 1);
`ifdef ALU_CHECK_CAPTURE_EN
    check("t2_fexp", first_exp, 32'h8888_8889);
    check("t2_fgot", first_got, 32'h8888_8888);
    check("t2_fidx", first_idx, 1);
`else
    check("t2_fexp", first_exp, 0);
`endif

    // fill to DEPTH, fifth ignored, drain
    clr();
    cyc(1, 3'b100, 32'h1, 32'h1, 0, 0);
    cyc(1, 3'b101, 32'h0, 32'h1, 0, 0);
    cyc(1, 3'b011, 32'h1, 32'h0, 0, 0);
    cyc(1, 3'b010, 32'h0, 32'h0, 0, 0);
    idle();
    check("t3_ready", stim_ready, 0);
    check("t3_busy", busy, 1);
    cyc(1, 3'b100, 32'h5, 32'h5, 0, 0);
    cyc(0, 3'd0, 0, 0, 1, 32'h2);
    cyc(0, 3'd0, 0, 0, 1, 32'hFFFF_FFFF);
    cyc(0, 3'd0, 0, 0, 1, 32'hFFFF_FFFF);
    cyc(0, 3'd0, 0, 0, 1, 32'hFFFF_FFFF);
    idle();
    check("t3_pass", pass_count, 4);
    check("t3_fail", fail_count, 0);
    check("t3_idle", busy, 0);

    // underflow and reserved opcode
    clr();
    cyc(0, 3'd0, 0, 0, 1, 32'h0);
    idle();
    check("t4_under", underflow_err, 1);
    check("t4_cnt", pass_count + fail_count, 0);
    cyc(1, 3'b110, 32'h3, 32'h4, 0, 0);
    idle();
    check("t4_ill", illegal_op_err, 1);
    check("t4_busy", busy, 0);

    // clear mid-operation discards the queue
    clr();
    cyc(1, 3'b100, 32'h1, 32'h2, 0, 0);
    cyc(1, 3'b100, 32'h3, 32'h4, 0, 0);
    cyc(1, 3'b100, 32'h5, 32'h6, 0, 0);
    clr();
    idle();
    check("t5_busy", busy, 0);
    check("t5_ready", stim_ready, 1);
    check("t5_flags", {underflow_err, illegal_op_err}, 0);
    check("t5_cnts", {pass_count, fail_count, first_idx}, 0);
    check("t5_first", {first_exp, first_got}, 0);
    cyc(0, 3'd0, 0, 0, 1, 32'h3);
    idle();
    check("t5_under", underflow_err, 1);

    // 16 mismatches saturate the 4-bit counter
    clr();
    cyc(1, 3'b000, 32'h0, 32'h0, 0, 0);
    for (int i = 0; i < 15; i++) cyc(1, 3'b000, 32'h0, 32'h0, 1, 32'h1);
    cyc(0, 3'd0, 0, 0, 1, 32'h1);
    idle();
    check("t6_sfail", s_fail, 4'hF);
    check("t6_fail", fail_count, 16);
    check("t6_spass", s_pass, 0);

    // randomized traffic
    clr();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      clear      = ($urandom_range(0, 299) == 0);
      stim_valid = ($urandom_range(0, 9) < 6);
      stim_op    = ($urandom_range(0, 19) == 0) ? 3'(6 + $urandom_range(0, 1)) : 3'($urandom_range(0, 5));
      stim_a     = pick();
      stim_b     = pick();
      if (mq.size() > 0) begin
        res_valid = ($urandom_range(0, 1) == 1);
        res_z     = ($urandom_range(0, 9) < 8) ? mq[0] : $urandom;
      end else begin
        res_valid = ($urandom_range(0, 19) == 0);
        res_z     = $urandom;
      end
    end
    idle();
    @(posedge clock); #3;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
